dpm_qshift_slice: RTL and testbench
===================================

Name: dpm_qshift_slice

Overview:
- Datapath-side Q register with the Q_SIO shift-in/shift-out pad interface.
- It is the other end of the ALK Q shift routing: it drives the bit leaving Q onto the Q_SIO line selected by DSIZE, and samples the returning Q_SIO bit into the vacated position.
- It also contains a step counter that sequences multi-cycle MUL/DIV shift loops and reports completion to microcode.

Parameters:
- QW, 32, Q register width; must be 32, because the pad taps sit at bits 0/7/15/31.
- SW, 5, step counter width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_h  in  1  synchronous reset, active high.
- q_op_h  in  2  Q operation: 00 hold, 01 load, 10 shift left, 11 shift right.
- dsize_h  in  2  data size: 00 byte (msb 7), 01 word (msb 15), 1x long (msb 31).
- q_d_h  in  32  load data.
- step_load_h  in  1  load the step counter.
- step_cnt_h  in  5  step counter load value.
- q_sio0_in_l, q_sio7_in_l, q_sio15_in_l, q_sio31_in_l  in  1 each  pad receivers; low = 1.
- q_sio0_out_l, q_sio7_out_l, q_sio15_out_l, q_sio31_out_l  out  1 each  open-drain drive; 0 pulls the pad low, 1 releases it.
- q_h  out  32  Q register contents.
- step_zero_h  out  1  step counter == 0.
- step_busy_h  out  1  step counter != 0.

Behaviour:
- Reset (synchronous, active high):
  - Q <= 0 and counter <= 0.
  - While reset_h is high, all *_out_l = 1 (released), regardless of q_op_h.
  - Reset asserted mid-sequence aborts the sequence at the next edge.
- msb index m is selected combinationally from dsize_h: 7, 15 or 31.
  - A dsize change takes effect in the same cycle, including mid-sequence.
- Hold (00): Q unchanged; all pads released.
- Load (01): Q <= q_d_h at the edge; all pads released.
- Shift left (10):
  - Q[m:0] <= {Q[m-1:0], ~q_sio0_in_l}.
  - Q[31:m+1] unchanged.
  - q_sio{m}_out_l = ~Q[m] (combinational from current Q); other pads released.
- Shift right (11):
  - Q[m:0] <= {~q_sio{m}_in_l, Q[m:1]}.
  - Q[31:m+1] unchanged.
  - q_sio0_out_l = ~Q[0]; other pads released.
- Pad rules:
  - Only one out pad is active per cycle; no pad is both driven and sampled by this block in the same op.
  - Pad outputs are combinational; shift results appear on q_h one edge later (latency 1).
- Step counter:
  - step_load_h has priority: counter <= step_cnt_h.
  - Otherwise, on shift ops (10/11) with counter != 0, counter decrements by 1.
  - The counter saturates at 0 and never wraps.
  - A shift with counter == 0 still shifts Q.
  - Loading 0 gives step_zero_h = 1 next cycle.
  - step_load_h together with a shift: the load wins and Q still shifts.
- step_zero_h / step_busy_h are registered-state decodes, mutually exclusive, valid one edge after the counter changes.
- Load/hold never alter the counter unless step_load_h is asserted.

Test Plan:
1. Reset then hold: assert reset_h one edge with q_op=01, q_d=FFFFFFFF -> q_h=00000000, all *_out_l=1, step_zero_h=1.
2. Byte SHL: load 0000_0081, dsize=00, q_op=10, q_sio0_in_l=0 -> q_sio7_out_l=0 during the cycle; next q_h=0000_0003; q_sio0_out_l, q_sio15_out_l and q_sio31_out_l remain 1.
3. Word SHR: load 1234_8001, dsize=01, q_op=11, q_sio15_in_l=0 -> q_sio0_out_l=0 during the cycle; next q_h=1234_C000.
4. Long SHR chain: load 0000_0001, dsize=10, q_sio31_in_l=1, 32 SHR cycles -> q_h=0 after cycle 1; q_sio0_out_l=0 only in cycle 1.
5. Step sequence: step_load with 5, then 5 SHL cycles -> step_busy_h=1 for 5 edges, step_zero_h=1 after the 5th, stays 0 count after a 6th shift (no wrap).
6. Priority/abort: step_load=3 concurrent with SHL -> count=3 and Q shifted; then assert reset_h mid-count -> count=0, Q=0, pads released.

Source files
------------

// File: rtl/dpm_qshift_slice.sv
// rtl/dpm_qshift_slice.sv - Datapath Q register with Q_SIO shift pads and MUL/DIV step counter
module dpm_qshift_slice #(
    parameter int QW = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          reset_h,
    input  logic [1:0]    q_op_h,
    input  logic [1:0]    dsize_h,
    input  logic [QW-1:0] q_d_h,
    input  logic          step_load_h,
    input  logic [SW-1:0] step_cnt_h,
    input  logic          q_sio0_in_l,
    input  logic          q_sio7_in_l,
    input  logic          q_sio15_in_l,
    input  logic          q_sio31_in_l,
    output logic          q_sio0_out_l,
    output logic          q_sio7_out_l,
    output logic          q_sio15_out_l,
    output logic          q_sio31_out_l,
    output logic [QW-1:0] q_h,
    output logic          step_zero_h,
    output logic          step_busy_h
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    logic [QW-1:0] q_q, q_d;
    logic [SW-1:0] cnt_q, cnt_d;

    logic [QW-1:0] mask;
    logic [QW-1:0] msb_bit;
    logic          sin_msb;
    logic          q_msb;
    logic [QW-1:0] shl_v;
    logic [QW-1:0] shr_v;

    // Active field is Q[m:0]; bits above m pass through untouched.
    always_comb begin
        mask    = {QW{1'b1}};
        sin_msb = ~q_sio31_in_l;
        q_msb   = q_q[31];
        case (dsize_h)
            2'b00: begin
                mask    = QW'(32'h0000_00FF);
                sin_msb = ~q_sio7_in_l;
                q_msb   = q_q[7];
            end
            2'b01: begin
                mask    = QW'(32'h0000_FFFF);
                sin_msb = ~q_sio15_in_l;
                q_msb   = q_q[15];
            end
            default: ;
        endcase
        msb_bit = mask ^ (mask >> 1);
        shl_v   = (((q_q << 1) | {{(QW-1){1'b0}}, ~q_sio0_in_l}) & mask) | (q_q & ~mask);
        shr_v   = ((q_q & mask) >> 1) | (sin_msb ? msb_bit : {QW{1'b0}}) | (q_q & ~mask);
    end

    always_comb begin
        q_d = q_q;
        case (q_op_h)
            OP_HOLD: q_d = q_q;
            OP_LOAD: q_d = q_d_h;
            OP_SHL:  q_d = shl_v;
            OP_SHR:  q_d = shr_v;
            default: q_d = q_q;
        endcase

        cnt_d = cnt_q;
        if (step_load_h) begin
            cnt_d = step_cnt_h;
        end else if (q_op_h[1] && (cnt_q != {SW{1'b0}})) begin
            cnt_d = cnt_q - SW'(1);
        end
    end

    // Open-drain pads: at most one is driven, and only while out of reset.
    always_comb begin
        q_sio0_out_l  = 1'b1;
        q_sio7_out_l  = 1'b1;
        q_sio15_out_l = 1'b1;
        q_sio31_out_l = 1'b1;
        if (!reset_h) begin
            if (q_op_h == OP_SHL) begin
                case (dsize_h)
                    2'b00:   q_sio7_out_l  = ~q_msb;
                    2'b01:   q_sio15_out_l = ~q_msb;
                    default: q_sio31_out_l = ~q_msb;
                endcase
            end else if (q_op_h == OP_SHR) begin
                q_sio0_out_l = ~q_q[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_h) begin
            q_q   <= {QW{1'b0}};
            cnt_q <= {SW{1'b0}};
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_h         = q_q;
    assign step_zero_h = (cnt_q == {SW{1'b0}});
    assign step_busy_h = (cnt_q != {SW{1'b0}});

endmodule

// File: tb/tb_dpm_qshift_slice.sv
// tb/tb_dpm_qshift_slice.sv - Directed self-checking bench for dpm_qshift_slice
module tb_dpm_qshift_slice;

    logic        clk;
    logic        reset_h;
    logic [1:0]  q_op_h;
    logic [1:0]  dsize_h;
    logic [31:0] q_d_h;
    logic        step_load_h;
    logic [4:0]  step_cnt_h;
    logic        q_sio0_in_l, q_sio7_in_l, q_sio15_in_l, q_sio31_in_l;
    logic        q_sio0_out_l, q_sio7_out_l, q_sio15_out_l, q_sio31_out_l;
    logic [31:0] q_h;
    logic        step_zero_h, step_busy_h;

    int checks;
    int failures;

    dpm_qshift_slice #(.QW(32), .SW(5)) dut (
        .clk(clk),
        .reset_h(reset_h),
        .q_op_h(q_op_h),
        .dsize_h(dsize_h),
        .q_d_h(q_d_h),
        .step_load_h(step_load_h),
        .step_cnt_h(step_cnt_h),
        .q_sio0_in_l(q_sio0_in_l),
        .q_sio7_in_l(q_sio7_in_l),
        .q_sio15_in_l(q_sio15_in_l),
        .q_sio31_in_l(q_sio31_in_l),
        .q_sio0_out_l(q_sio0_out_l),
        .q_sio7_out_l(q_sio7_out_l),
        .q_sio15_out_l(q_sio15_out_l),
        .q_sio31_out_l(q_sio31_out_l),
        .q_h(q_h),
        .step_zero_h(step_zero_h),
        .step_busy_h(step_busy_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pads();
        return {28'b0, q_sio31_out_l, q_sio15_out_l, q_sio7_out_l, q_sio0_out_l};
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        reset_h = 1'b1;
        q_op_h = 2'b10;
        dsize_h = 2'b10;
        q_d_h = 32'hFFFF_FFFF;
        step_load_h = 1'b0;
        step_cnt_h = 5'd0;
        q_sio0_in_l = 1'b1;
        q_sio7_in_l = 1'b1;
        q_sio15_in_l = 1'b1;
        q_sio31_in_l = 1'b1;

        // 1. reset overrides load; pads released even with a shift requested
        #1;
        chk("reset_pads_shl", pads(), 32'hF);
        q_op_h = 2'b01;
        tick();
        chk("reset_q", q_h, 32'h0);
        chk("reset_zero", {31'b0, step_zero_h}, 32'h1);
        chk("reset_busy", {31'b0, step_busy_h}, 32'h0);
        chk("reset_pads_load", pads(), 32'hF);

        // 2. byte shift left
        reset_h = 1'b0;
        q_op_h = 2'b01;
        q_d_h = 32'h0000_0081;
        tick();
        chk("load_81", q_h, 32'h0000_0081);
        dsize_h = 2'b00;
        q_op_h = 2'b10;
        q_sio0_in_l = 1'b0;
        #1;
        chk("byte_shl_pads", pads(), 32'hD);
        tick();
        chk("byte_shl_q", q_h, 32'h0000_0003);
        q_sio0_in_l = 1'b1;

        // 3. word shift right, upper half preserved
        q_op_h = 2'b01;
        q_d_h = 32'h1234_8001;
        tick();
        dsize_h = 2'b01;
        q_op_h = 2'b11;
        q_sio15_in_l = 1'b0;
        #1;
        chk("word_shr_pads", pads(), 32'hE);
        tick();
        chk("word_shr_q", q_h, 32'h1234_C000);
        q_sio15_in_l = 1'b1;

        // byte shift right, fill from pad 7, upper bytes preserved
        q_op_h = 2'b01;
        q_d_h = 32'hFFFF_FF00;
        tick();
        dsize_h = 2'b00;
        q_op_h = 2'b11;
        q_sio7_in_l = 1'b0;
        #1;
        chk("byte_shr_pads", pads(), 32'hF);
        tick();
        chk("byte_shr_q", q_h, 32'hFFFF_FF80);
        q_sio7_in_l = 1'b1;

        // 4. long shift right chain
        q_op_h = 2'b01;
        q_d_h = 32'h0000_0001;
        tick();
        dsize_h = 2'b10;
        q_op_h = 2'b11;
        q_sio31_in_l = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk($sformatf("long_shr_pad0_%0d", i), {31'b0, q_sio0_out_l}, (i == 0) ? 32'h0 : 32'h1);
            tick();
            if (i == 0) chk("long_shr_q1", q_h, 32'h0);
        end
        chk("long_shr_q32", q_h, 32'h0);

        // 5. step counter sequence and saturation
        q_op_h = 2'b00;
        step_load_h = 1'b1;
        step_cnt_h = 5'd5;
        tick();
        step_load_h = 1'b0;
        chk("step_load5_busy", {31'b0, step_busy_h}, 32'h1);
        chk("step_load5_zero", {31'b0, step_zero_h}, 32'h0);
        q_op_h = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("step_busy_%0d", i), {31'b0, step_busy_h}, (i < 4) ? 32'h1 : 32'h0);
            chk($sformatf("step_zero_%0d", i), {31'b0, step_zero_h}, (i < 4) ? 32'h0 : 32'h1);
        end
        tick();
        chk("step_nowrap_zero", {31'b0, step_zero_h}, 32'h1);
        chk("step_nowrap_busy", {31'b0, step_busy_h}, 32'h0);

        // load 0 gives zero next cycle; hold does not alter the count
        q_op_h = 2'b00;
        step_load_h = 1'b1;
        step_cnt_h = 5'd2;
        tick();
        step_cnt_h = 5'd0;
        tick();
        step_load_h = 1'b0;
        chk("step_load0_zero", {31'b0, step_zero_h}, 32'h1);
        step_load_h = 1'b1;
        step_cnt_h = 5'd1;
        tick();
        step_load_h = 1'b0;
        q_op_h = 2'b01;
        q_d_h = 32'h0;
        tick();
        chk("step_hold_load_keep", {31'b0, step_busy_h}, 32'h1);

        // 6. load priority with a concurrent shift, then reset abort
        q_op_h = 2'b01;
        q_d_h = 32'h0000_0001;
        tick();
        q_op_h = 2'b10;
        dsize_h = 2'b10;
        q_sio0_in_l = 1'b1;
        step_load_h = 1'b1;
        step_cnt_h = 5'd3;
        tick();
        step_load_h = 1'b0;
        chk("prio_q", q_h, 32'h0000_0002);
        chk("prio_busy", {31'b0, step_busy_h}, 32'h1);
        tick();
        chk("prio_q2", q_h, 32'h0000_0004);
        chk("prio_busy2", {31'b0, step_busy_h}, 32'h1);
        q_op_h = 2'b11;
        reset_h = 1'b1;
        #1;
        chk("abort_pads", pads(), 32'hF);
        tick();
        reset_h = 1'b0;
        q_op_h = 2'b00;
        chk("abort_q", q_h, 32'h0);
        chk("abort_zero", {31'b0, step_zero_h}, 32'h1);
        chk("abort_busy", {31'b0, step_busy_h}, 32'h0);
        #1;
        chk("abort_pads_after", pads(), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
